// File: rtl/exc_ctrl_pkg.sv
// Shared constants and types for the MEM/CP0 exception controller:
// ExcCode values, Status bit positions, FSM states and the commit record.
package exc_ctrl_pkg;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    localparam int ST_IE         = 0;
    localparam int ST_EXL        = 1;
    localparam int ST_IM_BASE    = 8;
    localparam int ST_HW_IM_BASE = 10;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_e;

    typedef struct packed {
        logic [4:0]  exc_code;
        logic        is_eret;
        logic [31:0] epc;
        logic        bd;
        logic [31:0] badvaddr;
        logic        badvaddr_we;
        logic [31:0] redirect_pc;
    } commit_t;

    // A delay-slot victim restarts at its branch so the branch re-executes.
    function automatic logic [31:0] victim_epc(input logic [31:0] pc, input logic in_ds);
        return in_ds ? pc - 32'd4 : pc;
    endfunction

endpackage

// File: rtl/exc_ctrl_int_sync.sv
// Per-line flop-chain synchroniser for the asynchronous hardware interrupt inputs.
module int_sync
    import exc_ctrl_pkg::*;
#(
    parameter int NUM_HW_INT  = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_HW_INT-1:0] async_i,
    output logic [NUM_HW_INT-1:0] sync_o
);

    logic [NUM_HW_INT-1:0] sync_d [SYNC_STAGES];
    logic [NUM_HW_INT-1:0] sync_q [SYNC_STAGES];

    always_comb begin
        sync_d[0] = async_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < SYNC_STAGES; i++) begin
            if (rst) begin
                sync_q[i] <= '0;
            end else begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/exc_ctrl.sv
// MEM/CP0 exception controller: picks one winning interrupt/exception/ERET,
// commits CP0 info for one cycle and holds a pipeline flush with redirect PC.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter int          NUM_HW_INT   = 6,
    parameter int          SYNC_STAGES  = 2,
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_HW_INT-1:0] hw_int_i,
    input  logic                  valid_i,
    input  logic [31:0]           pc_i,
    input  logic                  in_delay_slot_i,
    input  logic [31:0]           bad_addr_i,
    input  logic                  adel_if_i,
    input  logic                  ri_i,
    input  logic                  ov_i,
    input  logic                  sys_i,
    input  logic                  bp_i,
    input  logic                  eret_i,
    input  logic                  adel_mem_i,
    input  logic                  ades_i,
    input  logic [31:0]           status_i,
    input  logic [31:0]           cause_i,
    input  logic [31:0]           epc_i,
    output logic [NUM_HW_INT-1:0] int_pending_o,
    output logic                  exc_valid_o,
    output logic                  is_eret_o,
    output logic [4:0]            exc_code_o,
    output logic [31:0]           epc_o,
    output logic                  bd_o,
    output logic [31:0]           badvaddr_o,
    output logic                  badvaddr_we_o,
    output logic                  flush_o,
    output logic [31:0]           redirect_pc_o
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             exc_valid_q, exc_valid_d;
    logic             flush_q, flush_d;
    commit_t          info_q, info_d;

    commit_t winner;
    logic    has_winner;
    logic    int_req;
    logic    unused_bits;

    int_sync #(
        .NUM_HW_INT (NUM_HW_INT),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_int_sync (
        .clk    (clk),
        .rst    (rst),
        .async_i(hw_int_i),
        .sync_o (int_pending_o)
    );

    assign int_req = ((|(int_pending_o & status_i[ST_HW_IM_BASE +: NUM_HW_INT])) ||
                      (|(cause_i[9:8] & status_i[ST_IM_BASE +: 2]))) &&
                     status_i[ST_IE] && !status_i[ST_EXL];

    assign unused_bits = ^{status_i[31:ST_HW_IM_BASE+NUM_HW_INT], status_i[7:2],
                           cause_i[31:10], cause_i[7:0]};

    // MIPS priority chain; ERET sits between the decode-time and data-address faults.
    always_comb begin
        winner             = '0;
        has_winner         = 1'b1;
        winner.epc         = victim_epc(pc_i, in_delay_slot_i);
        winner.bd          = in_delay_slot_i;
        winner.redirect_pc = EXC_VECTOR;
        if (int_req) begin
            winner.exc_code = EXC_INT;
        end else if (adel_if_i) begin
            winner.exc_code    = EXC_ADEL;
            winner.badvaddr    = pc_i;
            winner.badvaddr_we = 1'b1;
        end else if (ri_i) begin
            winner.exc_code = EXC_RI;
        end else if (ov_i) begin
            winner.exc_code = EXC_OV;
        end else if (sys_i) begin
            winner.exc_code = EXC_SYS;
        end else if (bp_i) begin
            winner.exc_code = EXC_BP;
        end else if (eret_i) begin
            winner             = '0;
            winner.is_eret     = 1'b1;
            winner.redirect_pc = epc_i;
        end else if (adel_mem_i) begin
            winner.exc_code    = EXC_ADEL;
            winner.badvaddr    = bad_addr_i;
            winner.badvaddr_we = 1'b1;
        end else if (ades_i) begin
            winner.exc_code    = EXC_ADES;
            winner.badvaddr    = bad_addr_i;
            winner.badvaddr_we = 1'b1;
        end else begin
            has_winner = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        exc_valid_d = 1'b0;
        flush_d     = flush_q;
        info_d      = info_q;
        case (state_q)
            IDLE: begin
                if (valid_i && has_winner) begin
                    state_d     = FLUSH;
                    cnt_d       = CNT_LOAD;
                    exc_valid_d = 1'b1;
                    flush_d     = 1'b1;
                    info_d      = winner;
                end
            end
            FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    flush_d = 1'b0;
                    info_d  = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            exc_valid_q <= 1'b0;
            flush_q     <= 1'b0;
            info_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            exc_valid_q <= exc_valid_d;
            flush_q     <= flush_d;
            info_q      <= info_d;
        end
    end

    assign exc_valid_o   = exc_valid_q;
    assign flush_o       = flush_q;
    assign is_eret_o     = info_q.is_eret;
    assign exc_code_o    = info_q.exc_code;
    assign epc_o         = info_q.epc;
    assign bd_o          = info_q.bd;
    assign badvaddr_o    = info_q.badvaddr;
    assign badvaddr_we_o = exc_valid_q & info_q.badvaddr_we;
    assign redirect_pc_o = info_q.redirect_pc;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed scoreboard bench for exc_ctrl: expected commits are queued as
// stimulus is driven and popped when the controller raises exc_valid_o.
module tb_exc_ctrl;

    localparam int NHW = 6;

    logic           clk = 1'b0;
    logic           rst;
    logic [NHW-1:0] hw_int_i;
    logic           valid_i;
    logic [31:0]    pc_i;
    logic           in_delay_slot_i;
    logic [31:0]    bad_addr_i;
    logic           adel_if_i, ri_i, ov_i, sys_i, bp_i, eret_i, adel_mem_i, ades_i;
    logic [31:0]    status_i, cause_i, epc_i;
    logic [NHW-1:0] int_pending_o;
    logic           exc_valid_o, is_eret_o, bd_o, badvaddr_we_o, flush_o;
    logic [4:0]     exc_code_o;
    logic [31:0]    epc_o, badvaddr_o, redirect_pc_o;

    typedef struct packed {
        logic [4:0]  code;
        logic        eret;
        logic [31:0] epc;
        logic        bd;
        logic [31:0] badv;
        logic        badv_we;
        logic [31:0] redirect;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    exc_ctrl #(
        .NUM_HW_INT  (NHW),
        .SYNC_STAGES (2),
        .FLUSH_CYCLES(2),
        .EXC_VECTOR  (32'hBFC00380)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .hw_int_i       (hw_int_i),
        .valid_i        (valid_i),
        .pc_i           (pc_i),
        .in_delay_slot_i(in_delay_slot_i),
        .bad_addr_i     (bad_addr_i),
        .adel_if_i      (adel_if_i),
        .ri_i           (ri_i),
        .ov_i           (ov_i),
        .sys_i          (sys_i),
        .bp_i           (bp_i),
        .eret_i         (eret_i),
        .adel_mem_i     (adel_mem_i),
        .ades_i         (ades_i),
        .status_i       (status_i),
        .cause_i        (cause_i),
        .epc_i          (epc_i),
        .int_pending_o  (int_pending_o),
        .exc_valid_o    (exc_valid_o),
        .is_eret_o      (is_eret_o),
        .exc_code_o     (exc_code_o),
        .epc_o          (epc_o),
        .bd_o           (bd_o),
        .badvaddr_o     (badvaddr_o),
        .badvaddr_we_o  (badvaddr_we_o),
        .flush_o        (flush_o),
        .redirect_pc_o  (redirect_pc_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [4:0] code, input logic eret, input logic [31:0] epc,
                                input logic bd, input logic [31:0] badv, input logic badv_we,
                                input logic [31:0] redirect);
        exp_t e;
        e.code     = code;
        e.eret     = eret;
        e.epc      = epc;
        e.bd       = bd;
        e.badv     = badv;
        e.badv_we  = badv_we;
        e.redirect = redirect;
        return e;
    endfunction

    task automatic clear_inputs();
        valid_i         = 1'b0;
        pc_i            = '0;
        in_delay_slot_i = 1'b0;
        bad_addr_i      = '0;
        adel_if_i       = 1'b0;
        ri_i            = 1'b0;
        ov_i            = 1'b0;
        sys_i           = 1'b0;
        bp_i            = 1'b0;
        eret_i          = 1'b0;
        adel_mem_i      = 1'b0;
        ades_i          = 1'b0;
    endtask

    // Present the already-set flags with valid_i for one edge and queue the expected commit.
    task automatic applyStimulus(input exp_t e);
        valid_i = 1'b1;
        sb_q.push_back(e);
        step();
        clear_inputs();
    endtask

    // Wait (bounded) for the commit pulse, compare it, then check flush length and zeroing.
    task automatic checkOutput(input string tag);
        int   waited = 0;
        exp_t e;
        while (exc_valid_o !== 1'b1 && waited < 5) begin
            step();
            waited++;
        end
        check({tag, "_commit_seen"}, 32'(exc_valid_o), 32'd1);
        check({tag, "_sb_depth"}, sb_q.size(), 32'd1);
        e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        check({tag, "_code"}, 32'(exc_code_o), 32'(e.code));
        check({tag, "_eret"}, 32'(is_eret_o), 32'(e.eret));
        check({tag, "_epc"}, epc_o, e.epc);
        check({tag, "_bd"}, 32'(bd_o), 32'(e.bd));
        check({tag, "_bva_we"}, 32'(badvaddr_we_o), 32'(e.badv_we));
        if (e.badv_we) check({tag, "_bva"}, badvaddr_o, e.badv);
        check({tag, "_redirect"}, redirect_pc_o, e.redirect);
        check({tag, "_flush1"}, 32'(flush_o), 32'd1);
        step();
        check({tag, "_pulse_end"}, 32'(exc_valid_o), 32'd0);
        check({tag, "_flush2"}, 32'(flush_o), 32'd1);
        check({tag, "_redirect_hold"}, redirect_pc_o, e.redirect);
        check({tag, "_code_hold"}, 32'(exc_code_o), 32'(e.code));
        step();
        check({tag, "_flush_done"}, 32'(flush_o), 32'd0);
        check({tag, "_redirect_zero"}, redirect_pc_o, 32'd0);
        check({tag, "_epc_zero"}, epc_o, 32'd0);
        check({tag, "_eret_zero"}, 32'(is_eret_o), 32'd0);
    endtask

    initial begin
        logic [4:0] pulse_pat;
        pulse_pat = 5'b01001;
        clear_inputs();
        hw_int_i = '0;
        status_i = '0;
        cause_i  = '0;
        epc_i    = '0;
        rst      = 1'b1;
        step();
        step();
        check("rst_exc_valid", 32'(exc_valid_o), 32'd0);
        check("rst_flush", 32'(flush_o), 32'd0);
        check("rst_redirect", redirect_pc_o, 32'd0);
        check("rst_pending", 32'(int_pending_o), 32'd0);
        rst = 1'b0;

        $display("[TB] reset during flush");
        ov_i  = 1'b1;
        pc_i  = 32'h80000040;
        valid_i = 1'b1;
        step();
        clear_inputs();
        check("midrst_commit", 32'(exc_valid_o), 32'd1);
        check("midrst_code", 32'(exc_code_o), 32'h0c);
        rst = 1'b1;
        step();
        check("midrst_flush", 32'(flush_o), 32'd0);
        check("midrst_valid", 32'(exc_valid_o), 32'd0);
        check("midrst_redirect", redirect_pc_o, 32'd0);
        check("midrst_code0", 32'(exc_code_o), 32'd0);
        rst = 1'b0;
        step();

        $display("[TB] no evaluation without valid_i");
        sys_i = 1'b1;
        step();
        check("novalid", 32'(exc_valid_o), 32'd0);
        clear_inputs();
        step();

        $display("[TB] overflow");
        ov_i = 1'b1;
        pc_i = 32'h80001000;
        applyStimulus(mk(5'h0c, 1'b0, 32'h80001000, 1'b0, 32'h0, 1'b0, 32'hBFC00380));
        checkOutput("ov");

        $display("[TB] store address error in delay slot");
        ades_i          = 1'b1;
        bad_addr_i      = 32'h00000003;
        in_delay_slot_i = 1'b1;
        pc_i            = 32'h80000010;
        applyStimulus(mk(5'h05, 1'b0, 32'h8000000C, 1'b1, 32'h00000003, 1'b1, 32'hBFC00380));
        checkOutput("ades");

        $display("[TB] fetch address error");
        adel_if_i  = 1'b1;
        adel_mem_i = 1'b1;
        bad_addr_i = 32'h12345678;
        pc_i       = 32'h80000101;
        applyStimulus(mk(5'h04, 1'b0, 32'h80000101, 1'b0, 32'h80000101, 1'b1, 32'hBFC00380));
        checkOutput("adelif");

        $display("[TB] eret");
        eret_i = 1'b1;
        epc_i  = 32'h80000400;
        pc_i   = 32'h80003000;
        applyStimulus(mk(5'h00, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h80000400));
        checkOutput("eret");

        eret_i = 1'b1;
        ri_i   = 1'b1;
        pc_i   = 32'h80003004;
        applyStimulus(mk(5'h0a, 1'b0, 32'h80003004, 1'b0, 32'h0, 1'b0, 32'hBFC00380));
        checkOutput("ri_eret");

        $display("[TB] hardware interrupt");
        status_i = 32'h00001001;
        hw_int_i = 6'b000100;
        step();
        check("sync_stage1", 32'(int_pending_o), 32'd0);
        step();
        check("sync_stage2", 32'(int_pending_o), 32'h04);
        sys_i = 1'b1;
        pc_i  = 32'h80002000;
        applyStimulus(mk(5'h00, 1'b0, 32'h80002000, 1'b0, 32'h0, 1'b0, 32'hBFC00380));
        checkOutput("hwint");

        status_i = 32'h00001003;
        sys_i    = 1'b1;
        pc_i     = 32'h80002008;
        applyStimulus(mk(5'h08, 1'b0, 32'h80002008, 1'b0, 32'h0, 1'b0, 32'hBFC00380));
        checkOutput("exl_sys");

        $display("[TB] software interrupt");
        hw_int_i = '0;
        status_i = 32'h00000101;
        cause_i  = 32'h00000100;
        bp_i     = 1'b1;
        pc_i     = 32'h80002100;
        applyStimulus(mk(5'h00, 1'b0, 32'h80002100, 1'b0, 32'h0, 1'b0, 32'hBFC00380));
        checkOutput("swint");
        status_i = '0;
        cause_i  = '0;
        step();
        step();

        $display("[TB] back-to-back syscall");
        sys_i   = 1'b1;
        valid_i = 1'b1;
        pc_i    = 32'h80004000;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("b2b_pulse%0d", i), 32'(exc_valid_o), 32'(pulse_pat[i]));
        end
        clear_inputs();
        step();
        step();
        check("b2b_idle", 32'(flush_o), 32'd0);
        check("sb_drained", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Registered, parametrised exception/interrupt controller at the MEM/CP0 boundary of the 5-stage MIPS pipeline.
- Synchronises external interrupt lines and resolves MIPS-priority among interrupt and synchronous exceptions of the MEM-stage instruction.
- Produces one-cycle CP0 commit info: ExcCode, EPC, BD, BadVAddr.
- Drives a multi-cycle pipeline flush and redirect PC, covering both exception entry and ERET.

Parameters:
NUM_HW_INT, 6, external interrupt lines (1..6), mapped to Status.IM/Cause.IP bits 10..10+NUM_HW_INT-1
SYNC_STAGES, 2, flop depth of interrupt synchroniser (>=2)
FLUSH_CYCLES, 2, cycles flush_o stays high after commit (>=1)
EXC_VECTOR, 32'hBFC00380, exception entry PC

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
hw_int_i  in  NUM_HW_INT  asynchronous interrupt lines
valid_i  in  1  MEM-stage instruction valid
pc_i  in  32  MEM-stage instruction PC
in_delay_slot_i  in  1  MEM instruction is in a branch delay slot
bad_addr_i  in  32  MEM data address
adel_if_i, ri_i, ov_i, sys_i, bp_i, eret_i, adel_mem_i, ades_i  in  1 each  exception flags
status_i  in  32  CP0 Status
cause_i  in  32  CP0 Cause (bits 9:8 are software interrupts)
epc_i  in  32  CP0 EPC, used for ERET
int_pending_o  out  NUM_HW_INT  synchronised lines, for Cause.IP
exc_valid_o  out  1  one-cycle commit pulse
is_eret_o  out  1  commit is ERET
exc_code_o  out  5  Cause.ExcCode
epc_o  out  32  value for EPC
bd_o  out  1  Cause.BD
badvaddr_o  out  32  BadVAddr value
badvaddr_we_o  out  1  BadVAddr write enable
flush_o  out  1  pipeline flush
redirect_pc_o  out  32  new fetch PC, valid while flush_o=1

Behaviour:
- Reset: all outputs 0, synchroniser flops 0, state IDLE, flush counter 0. Reset takes effect the next edge, including mid-flush.
- Synchroniser: SYNC_STAGES-flop chain per line; int_pending_o = last stage.
- Interrupt request = ((int_pending_o & Status.IM[hw]) | (cause_i[9:8] & status_i[9:8])) != 0 && status_i[0]=1 (IE) && status_i[1]=0 (EXL).
- Evaluation occurs only in IDLE with valid_i=1. Otherwise all requests are ignored; interrupts stay pending.
- Priority, highest first, with ExcCode:
  - Int 0x00
  - adel_if 0x04 (BadVAddr=pc_i)
  - ri 0x0a
  - ov 0x0c
  - sys 0x08
  - bp 0x09
  - eret
  - adel_mem 0x04 (BadVAddr=bad_addr_i)
  - ades 0x05 (BadVAddr=bad_addr_i)
- FSM states:
  - IDLE -> FLUSH on any winner sampled at edge N.
  - FLUSH holds FLUSH_CYCLES cycles via down-counter, then returns to IDLE.
- Outputs registered; from cycle N+1:
  - exc_valid_o=1 for exactly one cycle.
  - flush_o=1 for FLUSH_CYCLES cycles.
  - redirect_pc_o and all info outputs held constant through FLUSH, zeroed on return to IDLE.
- Exception commit:
  - epc_o = in_delay_slot_i ? pc_i-4 : pc_i (32-bit wrap).
  - bd_o = in_delay_slot_i; is_eret_o=0.
  - redirect_pc_o = EXC_VECTOR.
- ERET commit: is_eret_o=1, exc_code_o=0, epc_o=0, bd_o=0, badvaddr_we_o=0, redirect_pc_o=epc_i.
- badvaddr_we_o pulses with exc_valid_o only for AdEL/AdES.
- Simultaneous events: exactly one winner per commit; losers are dropped, since the flush kills the instruction.

Decomposition:
- defines.vh holds:
  - ExcCode constants (INT, ADEL, ADES, SYS, BP, RI, OV)
  - Status bit indices (IE=0, EXL=1, IM base 8)
  - FSM state encodings
  - EXC_VECTOR default
- Sub-module int_sync(NUM_HW_INT, SYNC_STAGES): flop-chain synchroniser, instantiated once.

Test Plan:
- Reset mid-flush: ov_i at cycle 3, rst=1 at cycle 5 -> cycle 6 onward flush_o=0, exc_valid_o=0, all outputs 0.
- Overflow at pc 0x80001000, not in delay slot -> next cycle exc_valid_o=1, exc_code_o=0x0c, epc_o=0x80001000, bd_o=0, redirect_pc_o=0xBFC00380. flush_o high 2 cycles. badvaddr_we_o=0.
- ades_i with bad_addr_i=0x00000003 and in_delay_slot_i=1, pc_i=0x80000010 -> exc_code_o=0x05, epc_o=0x8000000C, bd_o=1, badvaddr_o=0x00000003, badvaddr_we_o=1.
- hw_int_i[2] asserted; status=0x00001001 (IM2 hw bit 12 set, IE=1) -> int_pending_o[2] after 2 cycles. Next valid_i commit gives exc_code_o=0x00 even with sys_i=1. Repeat with EXL=1 -> sys wins (0x08).
- eret_i with epc_i=0x80000400 -> is_eret_o=1, redirect_pc_o=0x80000400, badvaddr_we_o=0. ri_i plus eret_i together -> ri (0x0a) wins.
- Back-to-back: sys_i held high for 5 cycles -> exactly one exc_valid_o pulse per FLUSH_CYCLES+1 window. No evaluation during FLUSH.
